vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port access controller for the PPU's 2 KB nametable VRAM. Shares the one memory port between the renderer fetch engine (fixed-latency, priority) and the CPU-side PPUDATA path (request/acknowledge). It also translates 14-bit PPU bus addresses into 11-bit VRAM addresses according to the cartridge nametable mirroring mode. All state advances only on PPU-clock-enabled cycles.

## Interface
- STARVE_LIMIT, 3, consecutive enabled cycles a pending CPU request may lose before it is forced into the slot (range 1..15)
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- clk_en  in  1  PPU clock enable; all registers hold when low
- mirror  in  2  00 horizontal, 01 vertical, 10 single-screen low, 11 single-screen high
- ren_req  in  1  renderer read request, sampled per enabled cycle
- ren_addr  in  14  renderer PPU address
- ren_data  out  8  renderer read data
- ren_valid  out  1  ren_data valid (one enabled cycle)
- ren_miss  out  1  renderer request dropped by a forced CPU slot (one enabled cycle)
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  14  CPU PPU address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid with cpu_ack
- cpu_ack  out  1  request completed (one enabled cycle)
- cpu_range_err  out  1  with cpu_ack: address outside $2000-$3EFF, access suppressed
- vram_addr  out  11  memory address
- vram_we  out  1  memory write enable
- vram_wdata  out  8  memory write data
- vram_rdata  in  8  memory read data, combinational from vram_addr

## Operation
- Slot FSM: IDLE, REN, CPU. Each slot lasts exactly one enabled cycle. The next state is chosen at every enabled edge from the sampled requests.
- Grant at an enabled edge:
  - CPU if cpu_req and wait_cnt == STARVE_LIMIT. If ren_req is also high, pulse ren_miss.
  - Else REN if ren_req.
  - Else CPU if cpu_req and no CPU slot/ack is in flight (a CPU slot occurs at most once per request).
  - Else IDLE.
- At grant, latch the address, we, wdata and mirror into slot registers. vram_* is driven only from these registers.
- Mirroring, for A = latched addr: vram_addr = {m, A[9:0]}
  - m = A[11] for horizontal
  - m = A[10] for vertical
  - m = 0 for single-screen low
  - m = 1 for single-screen high
- vram_we = 1 only in a CPU slot with latched we = 1 and an in-range address. vram_we is 0 in IDLE/REN.
- Out-of-range CPU address (A[13]=0, or A[13:8] == 6'h3F): no memory access; cpu_rdata = 8'h00; cpu_range_err = 1 with the ack. Renderer addresses are not range-checked; they are mirrored as-is.
- wait_cnt (4 bit):
  - Clears on a CPU grant or when cpu_req is low.
  - Increments, saturating at STARVE_LIMIT, on each enabled edge where cpu_req is high and REN is granted.
- cpu_we/cpu_addr/cpu_wdata must be stable while cpu_req is high. cpu_req must drop, or present a new request, in the enabled cycle after cpu_ack.

## Timing
- Request sampled at enabled edge E0; slot occupies the cycle E0→E1. Write commits and read data registers at E1.
- At E1: ren_data/ren_valid (REN) or cpu_rdata/cpu_ack (CPU) update. Latency is one enabled cycle.
- Pulses (ren_valid, ren_miss, cpu_ack, cpu_range_err) last one enabled cycle and hold while clk_en is low.
- Back-to-back renderer requests on consecutive enabled cycles are served every cycle with no bubble.
- A CPU request that arrives while ren_req is held high is served after at most STARVE_LIMIT+1 enabled edges.
- Mirror mode changing mid-stream affects only slots granted after the change.
- Reset: state IDLE, wait_cnt 0, all outputs 0 (ren_data, cpu_rdata, vram_addr, vram_wdata = 0; all strobes low). A reset asserted during a CPU write slot before its commit edge suppresses the write. No ack is issued for a request interrupted by reset.

## Test plan
- Mirroring: CPU writes 8'hA5 to $2005 with mirror=00. Renderer reads $2405 → ren_data 8'hA5, ren_valid one cycle after the request. Renderer reads $2805 → vram_addr 11'h405, not A5. Repeat for modes 01/10/11: $2805 maps to 11'h005 in mode 01, 11'h005 in mode 10, 11'h405 in mode 11.
- Priority/starvation (STARVE_LIMIT=3): hold ren_req high continuously, raise cpu_req for a read at $2000. Required: 3 REN slots, then a CPU slot with ren_miss pulsed in that slot, cpu_ack on the following enabled edge, and REN slots resuming.
- Simultaneous first arrival: ren_req and cpu_req rise on the same edge. REN is granted first, CPU on the next edge, with no ren_miss.
- Range error: CPU write 8'h3C to $3F00. Required: cpu_ack and cpu_range_err high, vram_we never high, memory unchanged; a later read of $3F00 returns 8'h00 with cpu_range_err.
- clk_en gating: clk_en high 1 of every 4 cycles. Every pulse spans exactly 4 clk cycles, and latency is one enabled cycle.
- Reset mid-write: assert rst_n low between the CPU write grant and its commit edge. Required: the location keeps its old value, all outputs are 0 during reset, and no cpu_ack appears after release.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port nametable VRAM slot arbiter (renderer priority, CPU anti-starvation) with mirroring
module vram_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [1:0]  mirror,
  input  logic        ren_req,
  input  logic [13:0] ren_addr,
  output logic [7:0]  ren_data,
  output logic        ren_valid,
  output logic        ren_miss,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_range_err,
  output logic [10:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata
);
  typedef enum logic [1:0] {IDLE, REN, CPU} slot_t;
  slot_t state, next;
  logic [13:0] addr_q;
  logic we_q;
  logic [7:0] wdata_q;
  logic [1:0] mirror_q;
  logic [3:0] wait_cnt;
  logic busy, starve, in_range, page;
  // a request whose slot or ack is still in flight is neither re-granted nor counted as waiting
  always_comb begin
    busy = state == CPU || cpu_ack;
    starve = cpu_req && !busy && wait_cnt == 4'(STARVE_LIMIT);
    next = starve ? CPU : ren_req ? REN : (cpu_req && !busy) ? CPU : IDLE;
    in_range = addr_q[13] && addr_q[13:8] != 6'h3F;
    page = mirror_q == 2'b00 ? addr_q[11] : mirror_q == 2'b01 ? addr_q[10] : mirror_q[0];
  end
  assign vram_addr = {page, addr_q[9:0]};
  assign vram_we = state == CPU && we_q && in_range;
  assign vram_wdata = wdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      mirror_q <= '0;
      wait_cnt <= '0;
      ren_data <= '0;
      ren_valid <= 1'b0;
      ren_miss <= 1'b0;
      cpu_rdata <= '0;
      cpu_ack <= 1'b0;
      cpu_range_err <= 1'b0;
    end else if (clk_en) begin
      state <= next;
      if (next == CPU) begin
        addr_q <= cpu_addr;
        we_q <= cpu_we;
        wdata_q <= cpu_wdata;
        mirror_q <= mirror;
      end else if (next == REN) begin
        addr_q <= ren_addr;
        we_q <= 1'b0;
        mirror_q <= mirror;
      end
      wait_cnt <= (!cpu_req || busy || next == CPU) ? '0 :
                  (next == REN && wait_cnt != 4'(STARVE_LIMIT)) ? wait_cnt + 4'd1 : wait_cnt;
      ren_miss <= starve && ren_req;
      ren_valid <= state == REN;
      if (state == REN) ren_data <= vram_rdata;
      cpu_ack <= state == CPU;
      cpu_range_err <= state == CPU && !in_range;
      if (state == CPU) cpu_rdata <= (in_range && !we_q) ? vram_rdata : '0;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a slot-level reference model
module tb_vram_arbiter;
  localparam int LIM = 3;
  logic clk = 0, rst_n = 0, clk_en = 0;
  logic [1:0] mirror = 0;
  logic ren_req = 0, cpu_req = 0, cpu_we = 0;
  logic [13:0] ren_addr = 0, cpu_addr = 0;
  logic [7:0] cpu_wdata = 0, ren_data, cpu_rdata, vram_wdata, vram_rdata;
  logic ren_valid, ren_miss, cpu_ack, cpu_range_err, vram_we;
  logic [10:0] vram_addr;
  logic [7:0] mem [2048];
  logic [7:0] ref_mem [2048];
  int n_vec = 0, n_err = 0;
  int m_kind, m_lost;
  bit m_granted, cap_en, cap_creq, low_seen;
  logic [13:0] g_addr;
  logic g_we;
  logic [7:0] g_wd, e_ren_data, e_cpu_rdata;
  logic [1:0] g_mir;
  logic e_ren_valid, e_miss, e_ack, e_rerr;

  vram_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mirror(mirror),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_data(ren_data), .ren_valid(ren_valid), .ren_miss(ren_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_range_err(cpu_range_err),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  always #5 clk = ~clk;
  assign vram_rdata = mem[vram_addr];

  function automatic logic [10:0] phys(input logic [13:0] a, input logic [1:0] md);
    int nt = (int'(a) / 1024) % 4;
    int pg = md == 2'd0 ? nt / 2 : md == 2'd1 ? nt % 2 : int'(md) - 2;
    return 11'(pg * 1024 + int'(a) % 1024);
  endfunction

  function automatic bit in_rng(input logic [13:0] a);
    return a >= 14'h2000 && a < 14'h3F00;
  endfunction

  function automatic logic [13:0] gen_addr();
    int s = $urandom % 8;
    return s == 0 ? 14'($urandom) : s == 1 ? 14'(32'h3F00 + $urandom % 256) :
           14'(32'h2000 | (($urandom % 4) << 10) | ($urandom % 16));
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kind = 0; m_lost = 0; m_granted = 0;
    g_addr = 0; g_we = 0; g_wd = 0; g_mir = 0;
    e_ren_data = 0; e_cpu_rdata = 0; e_ren_valid = 0; e_miss = 0; e_ack = 0; e_rerr = 0;
  endtask

  task automatic model_step(input logic r, input logic [13:0] ra, input logic c, input logic [13:0] ca,
                            input logic cw, input logic [7:0] cd, input logic [1:0] mr);
    int k;
    logic [10:0] p = phys(g_addr, g_mir);
    e_ren_valid = m_kind == 1;
    e_ack = m_kind == 2;
    e_rerr = m_kind == 2 && !in_rng(g_addr);
    if (m_kind == 1) e_ren_data = ref_mem[p];
    if (m_kind == 2) begin
      e_cpu_rdata = (in_rng(g_addr) && !g_we) ? ref_mem[p] : 8'h00;
      if (in_rng(g_addr) && g_we) ref_mem[p] = g_wd;
    end
    k = (c && !m_granted && m_lost == LIM) ? 2 : r ? 1 : (c && !m_granted) ? 2 : 0;
    e_miss = k == 2 && r;
    if (!c) begin m_lost = 0; m_granted = 0; end
    else if (k == 2) begin m_lost = 0; m_granted = 1; end
    else if (k == 1 && !m_granted && m_lost < LIM) m_lost++;
    if (k == 1) begin g_addr = ra; g_we = 0; g_mir = mr; end
    if (k == 2) begin g_addr = ca; g_we = cw; g_wd = cd; g_mir = mr; end
    m_kind = k;
  endtask

  // the memory commits on the enabled edge using the slot outputs seen just before it
  task automatic cycle();
    logic en, rs, we, r, c, cw;
    logic [10:0] wa;
    logic [7:0] wd, cd;
    logic [13:0] ra, ca;
    logic [1:0] mr;
    @(negedge clk);
    en = clk_en; rs = rst_n; we = vram_we; wa = vram_addr; wd = vram_wdata;
    r = ren_req; ra = ren_addr; c = cpu_req; ca = cpu_addr; cw = cpu_we; cd = cpu_wdata; mr = mirror;
    @(posedge clk);
    #1;
    cap_en = en; cap_creq = c;
    if (!rs) model_reset();
    else if (en) begin
      if (we) mem[wa] = wd;
      model_step(r, ra, c, ca, cw, cd, mr);
    end
    chk("ren_data", ren_data, e_ren_data);
    chk("ren_valid", ren_valid, e_ren_valid);
    chk("ren_miss", ren_miss, e_miss);
    chk("cpu_rdata", cpu_rdata, e_cpu_rdata);
    chk("cpu_ack", cpu_ack, e_ack);
    chk("cpu_range_err", cpu_range_err, e_rerr);
    chk("vram_addr", vram_addr, phys(g_addr, g_mir));
    chk("vram_we", vram_we, m_kind == 2 && g_we && in_rng(g_addr));
    chk("vram_wdata", vram_wdata, g_wd);
  endtask

  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d);
    cpu_req = 0;
    cycle();
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 40 && !cpu_ack; i++) cycle();
    chk("cpu_ack_seen", cpu_ack, 1);
    cpu_req = 0;
  endtask

  task automatic ren_read(input logic [13:0] a, input logic [10:0] ea);
    ren_req = 1; ren_addr = a;
    cycle();
    chk("ren_slot_addr", vram_addr, ea);
    chk("ren_valid_early", ren_valid, 0);
    ren_req = 0;
    cycle();
    chk("ren_valid_late", ren_valid, 1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    model_reset();
    cycle();
    cycle();
    chk("reset_vaddr", vram_addr, 0);
    rst_n = 1; clk_en = 1;
    cycle();
    // mirroring
    cpu_access(1, 14'h2005, 8'hA5);
    chk("wr_range_err", cpu_range_err, 0);
    ren_read(14'h2405, 11'h005); chk("mir_h_2405", ren_data, 8'hA5);
    ren_read(14'h2805, 11'h405); chk("mir_h_2805", ren_data, 8'h00);
    mirror = 1; ren_read(14'h2805, 11'h005); chk("mir_v_2805", ren_data, 8'hA5);
    mirror = 2; ren_read(14'h2805, 11'h005); chk("mir_sl_2805", ren_data, 8'hA5);
    mirror = 3; ren_read(14'h2805, 11'h405); chk("mir_sh_2805", ren_data, 8'h00);
    // range error
    mirror = 0;
    cpu_access(1, 14'h2F00, 8'h11);
    cpu_access(1, 14'h3F00, 8'h3C);
    chk("rerr_wr_flag", cpu_range_err, 1);
    chk("rerr_mem", mem[11'h700], 8'h11);
    cpu_access(0, 14'h3F00, 8'h00);
    chk("rerr_rd_flag", cpu_range_err, 1);
    chk("rerr_rd_data", cpu_rdata, 8'h00);
    cpu_access(0, 14'h2F00, 8'h00);
    chk("rd_2f00", cpu_rdata, 8'h11);
    // starvation
    cpu_req = 0;
    cycle();
    ren_req = 1; ren_addr = 14'h2100; cpu_req = 1; cpu_we = 0; cpu_addr = 14'h2000;
    for (int i = 0; i < LIM; i++) begin cycle(); chk("starve_no_miss", ren_miss, 0); end
    cycle(); chk("starve_miss", ren_miss, 1); chk("starve_cpu_slot_addr", vram_addr, 11'h000);
    cycle(); chk("starve_ack", cpu_ack, 1); chk("starve_miss_end", ren_miss, 0);
    cpu_req = 0;
    cycle(); chk("starve_ren_resume", ren_valid, 1);
    ren_req = 0;
    cycle();
    // simultaneous arrival
    ren_req = 1; ren_addr = 14'h2405; cpu_req = 1; cpu_we = 0; cpu_addr = 14'h2005;
    cycle(); chk("sim_ren_first", ren_miss, 0);
    ren_req = 0;
    cycle(); chk("sim_ren_valid", ren_valid, 1); chk("sim_no_miss", ren_miss, 0);
    cycle(); chk("sim_cpu_ack", cpu_ack, 1); chk("sim_cpu_data", cpu_rdata, 8'hA5);
    cpu_req = 0;
    cycle();
    // reset between write grant and commit
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'h2005; cpu_wdata = 8'h77;
    cycle(); chk("rst_grant_we", vram_we, 1);
    rst_n = 0; cpu_req = 0;
    cycle(); chk("rst_ack_low", cpu_ack, 0); chk("rst_we_low", vram_we, 0);
    cycle();
    rst_n = 1;
    cycle();
    cycle(); chk("rst_no_ack", cpu_ack, 0); chk("rst_mem_kept", mem[11'h005], 8'hA5);
    // randomized traffic; the last quarter runs with clk_en one cycle in four
    low_seen = 0;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if (cap_en && !cap_creq) low_seen = 1;
      clk_en = i >= 3000 ? (i % 4 == 3) : ($urandom % 4 != 0);
      ren_req = ($urandom % 3) != 0;
      ren_addr = gen_addr();
      if ($urandom % 64 == 0) mirror = 2'($urandom);
      if (cpu_req && cpu_ack) cpu_req = 0;
      else if (!cpu_req && low_seen && $urandom % 3 == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = gen_addr(); cpu_wdata = 8'($urandom);
        low_seen = 0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
